// File: rtl/led_step_pkg.sv
// Shared pattern-mode and shift-direction encodings for the LED step sequencer.
package led_step_pkg;

  typedef enum logic [1:0] {
    MODE_RING   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_step_sequencer_if.sv
// Control inputs and LED outputs of the step sequencer, bundled for the board top.
interface led_step_sequencer_if #(
  parameter int LED_WIDTH = 4
);
  logic                 tick_in;
  logic                 en;
  logic [1:0]           mode;
  logic [LED_WIDTH-1:0] led;
  logic                 step;

  modport master (
    output tick_in, en, mode,
    input  led, step
  );

  modport slave (
    input  tick_in, en, mode,
    output led, step
  );
endinterface

// File: rtl/led_step_sequencer_rise_detect.sv
// Rising-edge detector for a level already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic tick_q;

  // Resetting to 1 keeps a level that is already high at release from counting as an edge.
  always_ff @(posedge clk) begin
    if (rst) tick_q <= 1'b1;
    else     tick_q <= in;
  end

  assign pulse = in & ~tick_q;
endmodule

// File: rtl/led_step_sequencer.sv
// Prescales divider edges into pattern steps and drives ring/bounce/count/hold LED patterns.
module led_step_sequencer
  import led_step_pkg::*;
#(
  parameter int LED_WIDTH = 4,
  parameter int STEP_DIV  = 2,
  parameter int DIV_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  led_step_sequencer_if.slave bus
);
  localparam logic [LED_WIDTH-1:0] LED_ONE  = {{(LED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(STEP_DIV - 1);

  function automatic logic is_onehot(input logic [LED_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  logic                 tick_edge;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  dir_e                 dir_q, dir_d;
  logic                 step_q, step_d;

  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .in    (bus.tick_in),
    .pulse (tick_edge)
  );

  always_comb begin
    cnt_d  = cnt_q;
    led_d  = led_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (tick_edge && bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (mode_e'(bus.mode))
          MODE_RING: begin
            if (!is_onehot(led_q)) begin
              led_d = LED_ONE;
              dir_d = DIR_LEFT;
            end else begin
              led_d = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
            end
          end
          MODE_BOUNCE: begin
            // Turn around at an endpoint instead of shifting off it, so no endpoint repeats.
            if (!is_onehot(led_q)) begin
              led_d = LED_ONE;
              dir_d = DIR_LEFT;
            end else if (dir_q == DIR_LEFT) begin
              if (led_q[LED_WIDTH-1]) begin
                led_d = led_q >> 1;
                dir_d = DIR_RIGHT;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;
                dir_d = DIR_LEFT;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          MODE_COUNT: led_d = led_q + 1'b1;
          default:    led_d = led_q;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      led_q  <= LED_ONE;
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.step = step_q;
endmodule
